// File: rtl/r5p_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and restoring
// divide over a shared 2*XW accumulator, BPC bits retired per CALC cycle.
module r5p_mdu #(
   parameter int XW  = 32,
   parameter int BPC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic [2:0]    req_op,
   input  logic [XW-1:0] req_rs1,
   input  logic [XW-1:0] req_rs2,
   input  logic          kill,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [XW-1:0] rsp_rd
);

   localparam int CW = $clog2(XW/BPC + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(XW/BPC);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
   localparam logic [XW-1:0] MINV = {1'b1, {(XW-1){1'b0}}};

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic            neg_q, spc_q;
   logic [XW-1:0]   m_q;
   logic [2*XW-1:0] acc_q, acc_s;

   // request decode: operand signedness, magnitudes and the early-out results
   logic            is_div, sgn1, sgn2, n1, n2, div0, ovf, neg_n;
   logic [XW-1:0]   abs1, abs2, spc_res;

   always_comb begin
      is_div  = req_op[2];
      sgn1    = is_div ? ~req_op[0] : (req_op[1:0] != 2'b11);
      sgn2    = is_div ? ~req_op[0] : ~req_op[1];
      n1      = sgn1 & req_rs1[XW-1];
      n2      = sgn2 & req_rs2[XW-1];
      abs1    = n1 ? -req_rs1 : req_rs1;
      abs2    = n2 ? -req_rs2 : req_rs2;
      neg_n   = (is_div & req_op[1]) ? n1 : (n1 ^ n2);
      div0    = is_div & (req_rs2 == '0);
      ovf     = is_div & ~req_op[0] & (req_rs1 == MINV) & (req_rs2 == '1);
      spc_res = div0 ? (req_op[1] ? req_rs1 : '1) : (req_op[1] ? '0 : MINV);
   end

   // BPC unrolled steps; acc = {hi, lo}: multiply {partial sum, multiplier},
   // divide {partial remainder, dividend/quotient}
   logic [XW:0] tmp, diff, sum;

   always_comb begin
      acc_s = acc_q;
      tmp   = '0;
      diff  = '0;
      sum   = '0;
      for (int i = 0; i < BPC; i++) begin
         if (op_q[2]) begin
            tmp  = {acc_s[2*XW-1:XW], acc_s[XW-1]};
            diff = tmp - {1'b0, m_q};
            if (!diff[XW]) acc_s = {diff[XW-1:0], acc_s[XW-2:0], 1'b1};
            else           acc_s = {tmp[XW-1:0],  acc_s[XW-2:0], 1'b0};
         end else begin
            sum   = {1'b0, acc_s[2*XW-1:XW]} + (acc_s[0] ? {1'b0, m_q} : {(XW+1){1'b0}});
            acc_s = {sum, acc_s[XW-1:1]};
         end
      end
   end

   logic [2*XW-1:0] prod;
   logic [XW-1:0]   quo, rem, fin;

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[XW-1:0] : acc_q[XW-1:0];
      rem  = neg_q ? -acc_q[2*XW-1:XW] : acc_q[2*XW-1:XW];
      if (spc_q)          fin = acc_q[XW-1:0];
      else if (!op_q[2])  fin = (op_q[1:0] == 2'b00) ? prod[XW-1:0] : prod[2*XW-1:XW];
      else                fin = op_q[1] ? rem : quo;
   end

   // early-out ops enter CALC with cnt=0 so they spend only the finalize cycle there
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         spc_q  <= 1'b0;
         m_q    <= '0;
         acc_q  <= '0;
         rsp_rd <= '0;
      end else begin
         case (state)
            IDLE: if (req_vld && !kill) begin
               op_q  <= req_op;
               neg_q <= neg_n;
               spc_q <= div0 | ovf;
               state <= CALC;
               if (div0 | ovf) begin
                  cnt   <= '0;
                  acc_q <= {{XW{1'b0}}, spc_res};
               end else begin
                  cnt   <= CNT_INIT;
                  m_q   <= is_div ? abs2 : abs1;
                  acc_q <= {{XW{1'b0}}, is_div ? abs1 : abs2};
               end
            end
            CALC: begin
               if (kill) state <= IDLE;
               else if (cnt != '0) begin
                  acc_q <= acc_s;
                  cnt   <= cnt - 1'b1;
               end else begin
                  rsp_rd <= fin;
                  state  <= DONE;
               end
            end
            DONE: if (kill || rsp_rdy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_rdy = (state == IDLE);
   assign rsp_vld = (state == DONE);

endmodule
